// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares one single-port BRAM (bypass read mode, one cycle read latency)
// between two requesters: port 0 (CPU fetch) and port 1 (debug dumper).
// Accesses are serialised, one every three clocks: IDLE -> ACCESS -> WAIT.
//
// Ports
//   clk, RESET_n                 system clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN        port N request (level), write enable,
//                                address and write data; held until gntN
//   gntN                         one-cycle grant pulse (the ACCESS cycle)
//   ackN                         one-cycle completion pulse (the IDLE cycle
//                                after WAIT)
//   rdataN                       read data, valid from ackN, held until the
//                                next port N read completes
//   busy                         high whenever the FSM is not in IDLE
//   bram_ad/bram_di/bram_wre     registered BRAM address, data, write enable
//   bram_ce                      BRAM clock enable, high in ACCESS only
//   bram_do                      BRAM data out, valid in the WAIT cycle
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter int AW         = 11,
  parameter int DW         = 8,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          RESET_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [AW-1:0] bram_ad,
  output logic [DW-1:0] bram_di,
  output logic          bram_wre,
  output logic          bram_ce,
  input  logic [DW-1:0] bram_do
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2
  } state_e;

  state_e        state_q, state_d;

  logic          gnt0_q, gnt1_q;
  logic          ack0_q, ack1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic [AW-1:0] bram_ad_q;
  logic [DW-1:0] bram_di_q;
  logic          bram_wre_q;
  logic          owner_q;       // port currently being served
  logic          op_we_q;       // current access is a write
  logic          last_owner_q;  // port granted most recently (round-robin)

  logic          any_req;
  logic          win1;          // 1 = port 1 wins this arbitration

  assign any_req = req0 | req1;

  // Winner selection. A lone requester always wins; on a tie the port that
  // was not served last wins, unless fixed priority hands it to port 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    win1 = 1'b0;
    if (req0 && req1) begin
      win1 = FIXED_PRIO ? 1'b0 : ~last_owner_q;
    end else begin
      win1 = req1;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (any_req) state_d = S_ACCESS;
      S_ACCESS: state_d = S_WAIT;
      S_WAIT:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: state-decoded outputs ----------------
  always_comb begin
    busy    = (state_q != S_IDLE);
    bram_ce = (state_q == S_ACCESS);
  end

  // ---------------- Registered datapath ----------------
  // gnt/ack are single-cycle pulses: cleared every cycle unless re-set.
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      bram_ad_q    <= '0;
      bram_di_q    <= '0;
      bram_wre_q   <= 1'b0;
      owner_q      <= 1'b0;
      op_we_q      <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            bram_ad_q    <= win1 ? addr1  : addr0;
            bram_di_q    <= win1 ? wdata1 : wdata0;
            bram_wre_q   <= win1 ? we1    : we0;
            op_we_q      <= win1 ? we1    : we0;
            owner_q      <= win1;
            last_owner_q <= win1;
            gnt0_q       <= ~win1;
            gnt1_q       <= win1;
          end else begin
            bram_wre_q <= 1'b0;
          end
        end
        S_ACCESS: begin
          // The BRAM has sampled WRE at this edge; drop it so it is only
          // ever seen high alongside CE.
          bram_wre_q <= 1'b0;
        end
        S_WAIT: begin
          bram_wre_q <= 1'b0;
          if (!op_we_q) begin
            if (owner_q) rdata1_q <= bram_do;
            else         rdata0_q <= bram_do;
          end
          ack0_q <= ~owner_q;
          ack1_q <= owner_q;
        end
        default: begin
          bram_wre_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign bram_ad  = bram_ad_q;
  assign bram_di  = bram_di_q;
  assign bram_wre = bram_wre_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Self-checking bench. The main instance (round-robin) is driven through
// directed scenarios followed by random traffic, with a behavioural model
// that predicts grants, acks, read data and BRAM pin activity from a
// cycle-timeline view of the arbiter (one access every three cycles). A
// second instance with fixed priority is used for the starvation scenario.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          RESET_n;

  // Main instance (round-robin)
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, ack0, gnt1, ack1, busy, bram_wre, bram_ce;
  logic [DW-1:0] rdata0, rdata1, bram_di;
  logic [AW-1:0] bram_ad;
  logic [DW-1:0] bram_do;

  // Fixed-priority instance
  logic          f_req0, f_we0, f_req1, f_we1;
  logic [AW-1:0] f_addr0, f_addr1;
  logic [DW-1:0] f_wdata0, f_wdata1;
  logic          f_gnt0, f_ack0, f_gnt1, f_ack1, f_busy, f_bram_wre, f_bram_ce;
  logic [DW-1:0] f_rdata0, f_rdata1, f_bram_di;
  logic [AW-1:0] f_bram_ad;
  logic [DW-1:0] f_bram_do;

  always #5 clk = ~clk;

  bram_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b0)) u_dut (
    .clk(clk), .RESET_n(RESET_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1),
    .busy(busy), .bram_ad(bram_ad), .bram_di(bram_di),
    .bram_wre(bram_wre), .bram_ce(bram_ce), .bram_do(bram_do)
  );

  bram_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b1)) u_fix (
    .clk(clk), .RESET_n(RESET_n),
    .req0(f_req0), .we0(f_we0), .addr0(f_addr0), .wdata0(f_wdata0),
    .gnt0(f_gnt0), .ack0(f_ack0), .rdata0(f_rdata0),
    .req1(f_req1), .we1(f_we1), .addr1(f_addr1), .wdata1(f_wdata1),
    .gnt1(f_gnt1), .ack1(f_ack1), .rdata1(f_rdata1),
    .busy(f_busy), .bram_ad(f_bram_ad), .bram_di(f_bram_di),
    .bram_wre(f_bram_wre), .bram_ce(f_bram_ce), .bram_do(f_bram_do)
  );

  assign f_bram_do = 8'h00;

  // Single-port BRAM, bypass read mode: a read clocked with CE appears on
  // DO in the following cycle; writes leave DO unchanged.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bram_ce) begin
      if (bram_wre) mem[bram_ad] <= bram_di;
      else          bram_do      <= mem[bram_ad];
    end
  end

  // ---------------- Reference model state ----------------
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            cyc;           // cycles since reset release
  int            m_gnt;         // cycle of the most recent grant
  logic          m_owner, m_last_owner, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] exp_rd0, exp_rd1;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [DW-1:0] init_byte(input int a);
    logic [AW-1:0] aa;
    aa = AW'(a);
    if (a == 0) return 8'h45;
    return aa[7:0] ^ 8'h3C ^ {aa[10:8], 5'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_reset();
    cyc          = 0;
    m_gnt        = -100;
    m_last_owner = 1'b1;
    m_owner      = 1'b0;
    m_we         = 1'b0;
    m_addr       = '0;
    m_wdata      = '0;
    exp_rd0      = '0;
    exp_rd1      = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt0"},  gnt0, 0);
    check({tag, "_gnt1"},  gnt1, 0);
    check({tag, "_ack0"},  ack0, 0);
    check({tag, "_ack1"},  ack1, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_ce"},    bram_ce, 0);
    check({tag, "_wre"},   bram_wre, 0);
    check({tag, "_ad"},    bram_ad, 0);
    check({tag, "_di"},    bram_di, 0);
    check({tag, "_rd0"},   rdata0, 0);
    check({tag, "_rd1"},   rdata1, 0);
  endtask

  // Timeline model: an access granted in cycle g occupies cycles g (ACCESS)
  // and g+1 (WAIT), completes with an ack in g+2, and the earliest next
  // grant is g+3, decided from the requests present at the end of g+2.
  task automatic model_and_check();
    logic e_g0, e_g1, e_a0, e_a1, e_busy, e_ce, e_wre, w1;
    e_g0 = 0; e_g1 = 0; e_a0 = 0; e_a1 = 0; w1 = 0;
    if (cyc == m_gnt + 2) begin
      if (m_owner) e_a1 = 1'b1; else e_a0 = 1'b1;
      if (m_we)         ref_mem[m_addr] = m_wdata;
      else if (m_owner) exp_rd1 = ref_mem[m_addr];
      else              exp_rd0 = ref_mem[m_addr];
    end
    if ((cyc - m_gnt >= 3) && (req0 || req1)) begin
      if (req0 && req1) w1 = (m_last_owner == 1'b0);
      else              w1 = req1;
      m_gnt        = cyc;
      m_owner      = w1;
      m_last_owner = w1;
      m_we         = w1 ? we1 : we0;
      m_addr       = w1 ? addr1 : addr0;
      m_wdata      = w1 ? wdata1 : wdata0;
      e_g0 = ~w1;
      e_g1 = w1;
    end
    e_busy = (cyc - m_gnt) < 2;
    e_ce   = (cyc == m_gnt);
    e_wre  = e_ce && m_we;
    check("gnt0", gnt0, e_g0);
    check("gnt1", gnt1, e_g1);
    check("ack0", ack0, e_a0);
    check("ack1", ack1, e_a1);
    check("busy", busy, e_busy);
    check("bram_ce", bram_ce, e_ce);
    check("bram_wre", bram_wre, e_wre);
    check("rdata0", rdata0, exp_rd0);
    check("rdata1", rdata1, exp_rd1);
    check("gnt_excl", gnt0 & gnt1, 0);
    check("ack_excl", ack0 & ack1, 0);
    if (e_ce) begin
      check("bram_ad", bram_ad, m_addr);
      if (m_we) check("bram_di", bram_di, m_wdata);
    end
  endtask

  // Advance one cycle; outputs are sampled on the falling edge, and the
  // caller drives the next inputs right after.
  task automatic step();
    @(negedge clk);
    cyc++;
    model_and_check();
  endtask

  task automatic do_reset();
    @(negedge clk);
    RESET_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs("rst");
    @(negedge clk);
    RESET_n = 1'b1;
    cyc     = 0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return '1;
    return AW'($urandom_range(0, 31));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] saved_rd1;
    int base, k;
    int cnt0, cnt1;

    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = init_byte(i);
      ref_mem[i] = init_byte(i);
    end
    bram_do = '0;
    RESET_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    f_req0 = 0; f_we0 = 0; f_addr0 = '0; f_wdata0 = '0;
    f_req1 = 0; f_we1 = 0; f_addr1 = '0; f_wdata1 = '0;
    model_reset();

    // ---- Reset values ----
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // ---- Single read of addr 0 by port 0 ----
    RESET_n = 1'b1;
    cyc = 0;
    req0 = 1; we0 = 0; addr0 = '0;
    step();
    check("t1_gnt0_c1", gnt0, 1);
    check("t1_ce_c1", bram_ce, 1);
    req0 = 0;
    step();
    check("t1_gnt0_c2", gnt0, 0);
    step();
    check("t1_ack0_c3", ack0, 1);
    check("t1_rdata0", rdata0, 8'h45);
    check("t1_rdata1", rdata1, 8'h00);
    repeat (2) step();

    // ---- Both ports held high just after reset: grants 0,1,0,1 ----
    do_reset();
    req0 = 1; we0 = 0; addr0 = 11'h00A;
    req1 = 1; we1 = 0; addr1 = 11'h00B;
    cnt0 = 2; cnt1 = 2;
    for (int c = 1; c <= 12; c++) begin
      step();
      check("t2_gnt0", gnt0, (c == 1 || c == 7));
      check("t2_gnt1", gnt1, (c == 4 || c == 10));
      check("t2_ack0", ack0, (c == 3 || c == 9));
      check("t2_ack1", ack1, (c == 6 || c == 12));
      if (gnt0) begin
        cnt0--;
        if (cnt0 == 0) req0 = 0; else addr0 = 11'h020;
      end
      if (gnt1) begin
        cnt1--;
        if (cnt1 == 0) req1 = 0; else addr1 = 11'h021;
      end
    end
    repeat (3) step();

    // ---- Port 1 writes 0xA5 to 0x7FF, then port 0 reads it ----
    saved_rd1 = exp_rd1;
    base = cyc;
    check("t4_wre_idle", bram_wre, 0);
    req1 = 1; we1 = 1; addr1 = 11'h7FF; wdata1 = 8'hA5;
    step();
    check("t4_gnt1", gnt1, 1);
    check("t4_wre_access", bram_wre, 1);
    req1 = 0; we1 = 0;
    step();
    check("t4_wre_wait", bram_wre, 0);
    step();
    check("t4_ack1", ack1, 1);
    check("t4_wre_ack", bram_wre, 0);
    check("t4_rdata1_kept", rdata1, saved_rd1);
    req0 = 1; we0 = 0; addr0 = 11'h7FF;
    step();
    check("t4_gnt0", gnt0, 1);
    check("t4_cycle", cyc - base, 4);
    req0 = 0;
    step();
    step();
    check("t4_ack0", ack0, 1);
    check("t4_rdata0", rdata0, 8'hA5);
    repeat (2) step();

    // ---- Fixed priority: port 1 starves while port 0 keeps requesting ----
    f_req0 = 1; f_addr0 = 11'h001;
    f_req1 = 1; f_addr1 = 11'h002;
    for (int c = 0; c < 30; c++) begin
      step();
      check("t3_no_gnt1", f_gnt1, 0);
    end
    k = 0;
    while (!f_gnt0 && k < 6) begin
      step();
      check("t3_no_gnt1", f_gnt1, 0);
      k++;
    end
    check("t3_gnt0_seen", f_gnt0, 1);
    f_req0 = 0;
    for (int c = 1; c <= 3; c++) begin
      step();
      check("t3_gnt1", f_gnt1, (c == 3));
    end
    f_req1 = 0;
    repeat (3) step();

    // ---- Reset asserted during the ACCESS cycle of a port 0 read ----
    req0 = 1; we0 = 0; addr0 = 11'h003;
    step();
    check("t5_gnt0", gnt0, 1);
    req0 = 0;
    RESET_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("t5_rst");
    @(negedge clk);
    check_reset_outputs("t5_hold");
    @(negedge clk);
    RESET_n = 1'b1;
    cyc = 0;
    req0 = 1; we0 = 0; addr0 = 11'h003;
    step();
    check("t5_regnt0", gnt0, 1);
    req0 = 0;
    step();
    step();
    check("t5_ack0", ack0, 1);
    check("t5_rdata0", rdata0, init_byte(3));
    repeat (2) step();

    // ---- Random traffic on both ports ----
    for (int n = 0; n < 10000; n++) begin
      step();
      if (!req0 || gnt0) begin
        req0   = ($urandom_range(0, 3) != 0);
        we0    = $urandom_range(0, 1) == 1;
        addr0  = rand_addr();
        wdata0 = DW'($urandom);
      end
      if (!req1 || gnt1) begin
        req1   = ($urandom_range(0, 3) != 0);
        we1    = $urandom_range(0, 1) == 1;
        addr1  = rand_addr();
        wdata1 = DW'($urandom);
      end
    end
    req0 = 0; req1 = 0;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
